// File: rtl/xor_write_scheduler.sv
// Write-request FIFO that drains up to two writes per cycle into the xor_memory write ports, oldest entry on port 1.
// Build option XWS_COALESCE_EN: a same-address head/next pair issues only the newer write and pops both.
module xor_write_scheduler #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ADDR_W-1:0]        in_addr,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     mem_stall,
   output logic [ADDR_W-1:0]        wa1,
   output logic [DATA_W-1:0]        w1,
   output logic [ADDR_W-1:0]        wa2,
   output logic [DATA_W-1:0]        w2,
   output logic [3:0]               enW,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     busy
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ADDR_W-1:0] addr_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PW-1:0]     rd_ptr, wr_ptr, nx_ptr;
   logic              push;
   logic [1:0]        pop;
   logic              iss1, iss2;
   logic [ADDR_W-1:0] head_addr, next_addr, p1_addr;
   logic [DATA_W-1:0] head_data, next_data, p1_data;

   assign in_ready  = !rst && (count < FULL);
   assign push      = in_valid && in_ready;
   assign nx_ptr    = rd_ptr + PW'(1);
   assign head_addr = addr_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign next_addr = addr_mem[nx_ptr];
   assign next_data = data_mem[nx_ptr];
   assign busy      = (count != '0) || (enW != 4'b0000);

   always_comb begin
      pop     = 2'd0;
      iss1    = 1'b0;
      iss2    = 1'b0;
      p1_addr = head_addr;
      p1_data = head_data;
      if (!mem_stall) begin
         if (count == CW'(1)) begin
            pop  = 2'd1;
            iss1 = 1'b1;
         end else if (count >= CW'(2)) begin
            if (head_addr != next_addr) begin
               pop  = 2'd2;
               iss1 = 1'b1;
               iss2 = 1'b1;
            end else begin
`ifdef XWS_COALESCE_EN
               // older write is dead: the newer one overwrites it anyway
               pop     = 2'd2;
               iss1    = 1'b1;
               p1_addr = next_addr;
               p1_data = next_data;
`else
               pop  = 2'd1;
               iss1 = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr] <= in_addr;
         data_mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         wa1    <= '0;
         w1     <= '0;
         wa2    <= '0;
         w2     <= '0;
         enW    <= 4'b0000;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         rd_ptr <= rd_ptr + PW'(pop);
         count  <= count + CW'(push) - CW'(pop);
         enW    <= {2'b00, iss2, iss1};
         // unused ports keep their last address/data
         if (iss1) begin
            wa1 <= p1_addr;
            w1  <= p1_data;
         end
         if (iss2) begin
            wa2 <= next_addr;
            w2  <= next_data;
         end
      end
   end
endmodule

// File: tb/tb_xor_write_scheduler.sv
// Directed plus randomized check of xor_write_scheduler against a queue-based reference model.
module tb_xor_write_scheduler;
   localparam int AW = 10;
   localparam int DW = 8;
   localparam int D  = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_addr = '0;
   logic [DW-1:0] in_data = '0;
   logic          mem_stall = 1'b0;
   logic [AW-1:0] wa1, wa2;
   logic [DW-1:0] w1, w2;
   logic [3:0]    enW;
   logic [3:0]    count;
   logic          busy;

   xor_write_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_addr(in_addr), .in_data(in_data), .mem_stall(mem_stall),
      .wa1(wa1), .w1(w1), .wa2(wa2), .w2(w2), .enW(enW),
      .count(count), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          q[$];
   logic [AW-1:0] ewa1 = '0, ewa2 = '0;
   logic [DW-1:0] ew1 = '0, ew2 = '0;
   logic [3:0]    een = '0;
   logic [DW-1:0] gmem [int];
   logic [DW-1:0] dmem [int];
   int            tests = 0;
   int            fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock edge of the reference: issue from the pre-edge queue, then accept.
   task automatic model_edge(input logic v, input ent_t e, input logic stall);
      int   n;
      ent_t h, x;
      n   = q.size();
      een = 4'b0000;
      if (!stall) begin
         if (n == 1) begin
            h = q.pop_front();
            gmem[int'(h.a)] = h.d;
            een = 4'b0001; ewa1 = h.a; ew1 = h.d;
         end else if (n >= 2) begin
            if (q[0].a != q[1].a) begin
               h = q.pop_front();
               x = q.pop_front();
               gmem[int'(h.a)] = h.d;
               gmem[int'(x.a)] = x.d;
               een = 4'b0011; ewa1 = h.a; ew1 = h.d; ewa2 = x.a; ew2 = x.d;
            end else begin
`ifdef XWS_COALESCE_EN
               h = q.pop_front();
               x = q.pop_front();
               gmem[int'(h.a)] = h.d;
               gmem[int'(x.a)] = x.d;
               een = 4'b0001; ewa1 = x.a; ew1 = x.d;
`else
               h = q.pop_front();
               gmem[int'(h.a)] = h.d;
               een = 4'b0001; ewa1 = h.a; ew1 = h.d;
`endif
            end
         end
      end
      if (v && n < D)
         q.push_back(e);
   endtask

   task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic stall, input string tag);
      ent_t e;
      e.a = a;
      e.d = d;
      in_valid  = v;
      in_addr   = a;
      in_data   = d;
      mem_stall = stall;
      #1;
      chk({tag, ".in_ready"}, in_ready, q.size() < D);
      @(posedge clk);
      model_edge(v, e, stall);
      #1;
      if (enW[0]) dmem[int'(wa1)] = w1;
      if (enW[1]) dmem[int'(wa2)] = w2;
      chk({tag, ".enW"},  enW,   een);
      chk({tag, ".wa1"},  wa1,   ewa1);
      chk({tag, ".w1"},   w1,    ew1);
      chk({tag, ".wa2"},  wa2,   ewa2);
      chk({tag, ".w2"},   w2,    ew2);
      chk({tag, ".count"}, count, q.size());
      chk({tag, ".busy"}, busy,  (q.size() != 0) || (een != 0));
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, ".enW"},      enW,      4'b0000);
      chk({tag, ".count"},    count,    0);
      chk({tag, ".in_ready"}, in_ready, 0);
      chk({tag, ".busy"},     busy,     0);
      chk({tag, ".wa1"},      wa1,      0);
      chk({tag, ".w1"},       w1,       0);
      chk({tag, ".wa2"},      wa2,      0);
      chk({tag, ".w2"},       w2,       0);
   endtask

   task automatic mid_reset(input string tag);
      rst = 1'b1;
      #1;
      check_reset_state(tag);
      q.delete();
      een = '0; ewa1 = '0; ew1 = '0; ewa2 = '0; ew2 = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk({tag, ".ready_after"}, in_ready, 1);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20 && q.size() != 0; i++)
         step(1'b0, '0, '0, 1'b0, tag);
      step(1'b0, '0, '0, 1'b0, tag);
   endtask

   initial begin
      #1;
      check_reset_state("reset");
      #11;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: single pushes flow straight through port 1
      step(1'b1, 10'd10, 8'd10, 1'b0, "t1.push10");
      step(1'b1, 10'd20, 8'd20, 1'b0, "t1.push20");
      step(1'b0, '0, '0, 1'b0, "t1.iss20");
      drain("t1.drain");

      // 2: paired issue after stall release
      step(1'b1, 10'd10, 8'd10, 1'b1, "t2.p0");
      step(1'b1, 10'd20, 8'd20, 1'b1, "t2.p1");
      step(1'b1, 10'd30, 8'd30, 1'b1, "t2.p2");
      step(1'b1, 10'd40, 8'd40, 1'b1, "t2.p3");
      drain("t2.drain");

      // 3: same-address pair
      step(1'b1, 10'd5, 8'hAA, 1'b1, "t3.p0");
      step(1'b1, 10'd5, 8'hBB, 1'b1, "t3.p1");
      drain("t3.drain");

      // 4: fill, refused 9th, drain, wrap
      for (int i = 0; i < 9; i++)
         step(1'b1, AW'(100 + i), DW'(i + 1), 1'b1, "t4.fill");
      chk("t4.full_ready", in_ready, 0);
      drain("t4.drain");
      step(1'b1, 10'd77, 8'h77, 1'b0, "t4.wrap_push");
      drain("t4.wrap_drain");

      // 5: async reset mid-drain
      for (int i = 0; i < 5; i++)
         step(1'b1, AW'(200 + i), DW'(i + 8'h50), 1'b1, "t5.fill");
      step(1'b0, '0, '0, 1'b0, "t5.rel");
      mid_reset("t5.rst");
      drain("t5.after");

      // 6: continuous distinct pushes
      for (int i = 0; i < 16; i++) begin
         step(1'b1, AW'(i), DW'(i + 8'h30), 1'b0, "t6.stream");
         chk("t6.count_le1", count <= 1, 1);
      end
      drain("t6.drain");

      // randomized traffic over a small address range to provoke conflicts
      for (int i = 0; i < 400; i++)
         step(($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), DW'($urandom),
              ($urandom_range(0, 4) == 0), "rnd");
      drain("rnd.drain");

      chk("mem.size", dmem.size(), gmem.size());
      foreach (gmem[k]) begin
         chk("mem.exists", dmem.exists(k), 1);
         if (dmem.exists(k))
            chk("mem.data", dmem[k], gmem[k]);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/xor_write_scheduler.md
Name: xor_write_scheduler

Overview:
- Upstream write-side feeder for the 2-write/4-read XOR memory (xor_memory).
- Buffers a single stream of write requests in a FIFO and drains it into the memory's two write ports (wa1/w1, wa2/w2, enW), up to two writes per cycle.
- Never issues the same address on both ports in one cycle.
- Preserves program order: older entry always on port 1.

Parameters:
- ADDR_W, 10, address width; matches memory wa1/wa2.
- DATA_W, 8, data width; matches memory w1/w2.
- DEPTH, 8, FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  write request valid.
- in_ready  output  1  scheduler can accept a request.
- in_addr  input  ADDR_W  request address.
- in_data  input  DATA_W  request data.
- mem_stall  input  1  hold off issue this cycle.
- wa1  output  ADDR_W  port-1 write address.
- w1  output  DATA_W  port-1 write data.
- wa2  output  ADDR_W  port-2 write address.
- w2  output  DATA_W  port-2 write data.
- enW  output  4  write enables; bit0 = port 1, bit1 = port 2, bits[3:2] tied 0.
- count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- busy  output  1  count != 0 or any enW bit set.

Behaviour:
- Reset (async):
  - FIFO pointers, count, wa1/wa2/w1/w2 and enW all go to 0.
  - in_ready = 0 while rst is high.
- Accept:
  - in_ready = !rst && (count < DEPTH), combinational from the registered count.
  - Push on an edge with in_valid && in_ready.
  - No push-when-full pass-through, even if a pop occurs the same cycle.
- Issue, evaluated each rising edge on pre-edge FIFO state; outputs are registered:
  - mem_stall = 1: enW <= 0, no pop. Address/data outputs hold their values.
  - count == 0: enW <= 0.
  - count == 1: head to port 1, enW <= 4'b0001, pop 1.
  - count ≥ 2, head.addr != next.addr: head to port 1, next to port 2, enW <= 4'b0011, pop 2.
  - count ≥ 2, head.addr == next.addr: conflict handling, see Optional Feature.
- When enW bit = 0, the corresponding port's address/data outputs hold their last values.
- Latency: a request pushed at edge N is issued on ports at edge N+1 at the earliest, provided it is at the head or next-to-head and no stall.
- Simultaneous push and pop in one edge: count += pushes − pops.
- Pointer wrap-around uses modulo DEPTH.
- The FIFO never reorders entries.
- Reset mid-operation: all queued entries are discarded and enW clears immediately (async). No partial writes are issued after rst deasserts.
- in_data/in_addr are ignored when in_valid = 0.

Optional Feature:
- Macro: XWS_COALESCE_EN.
- Defined: a same-address head/next pair is coalesced.
  - Only next (newer) is issued, on port 1, enW <= 4'b0001.
  - Both entries are popped; the older write is dropped.
  - Chained duplicates beyond two are handled over subsequent cycles.
- Undefined: a same-address pair issues head only on port 1, enW <= 4'b0001, pop 1. Next stays at head for the following cycle.
- In both builds, the final memory contents equal those of in-order sequential writes.

Test Plan:
1. Reset, then push (10,10), (20,20) on consecutive cycles.
   - Edge after first push: wa1 = 10, w1 = 10, enW = 0001.
   - Then: wa1 = 20, w1 = 20, enW = 0001.
   - count returns to 0.
2. mem_stall = 1, push (10,10), (20,20), (30,30), (40,40); then release stall.
   - First issue: wa1 = 10, wa2 = 20, enW = 0011.
   - Next: wa1 = 30, wa2 = 40, enW = 0011.
   - Then enW = 0.
3. Stall, push (5,0xAA), (5,0xBB); release.
   - Without macro: (5,AA) then (5,BB), each with enW = 0001 on consecutive cycles.
   - With XWS_COALESCE_EN: a single wa1 = 5, w1 = 0xBB, enW = 0001.
4. Stall, push 8 requests.
   - count = 8, in_ready = 0; a 9th in_valid is not accepted.
   - Release: 4 cycles of enW = 0011, entries in order.
   - Pointers wrap; a further push issues correctly.
5. Stall, push 5 entries; release; assert rst async mid-drain.
   - enW = 0 and count = 0 immediately.
   - After deassert, no stale writes appear; in_ready = 1.
6. Continuous one-per-cycle pushes of distinct addresses 0..15, no stall.
   - All 16 addresses issued exactly once, in order.
   - count ≤ 1 throughout.
